header_encoder: RTL

Transmit-side framer for the 16-bit ADC event stream. On a start request it emits one event packet: guaranteed idle word 16'h0000, six header words marked with bits [15:14]=2'b11 that carry timestamp, spill, slot, crate and event number, then NSAMPLES payload words. It sits between the sample buffer and the serializer, and is the exact counterpart of the receiving header decoder.

---
 rtl/header_enc_pkg.sv | 25 ++
 rtl/header_word_pack.sv | 28 ++
 rtl/header_encoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/header_enc_pkg.sv
// rtl/header_enc_pkg.sv - shared types and constants for the event packet header encoder
package header_enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_TRAIL,
        ST_GAP
    } enc_state_t;

    localparam logic [1:0]  HDR_MARK  = 2'b11;
    localparam logic [1:0]  TRL_MARK  = 2'b10;
    localparam logic [1:0]  PL_MARK   = 2'b00;
    localparam logic [15:0] IDLE_WORD = 16'h0000;

    localparam int TS_W      = 29;
    localparam int SPILL_W   = 10;
    localparam int SLOT_W    = 5;
    localparam int CRATE_W   = 5;
    localparam int EVT_W     = 16;
    localparam int SMP_W     = 14;
    localparam int HDR_WORDS = 6;

endpackage

// File: rtl/header_word_pack.sv
// rtl/header_word_pack.sv - combinational mapping of event fields and word index to a header word
module header_word_pack
    import header_enc_pkg::*;
(
    input  logic [TS_W-1:0]    timestamp,
    input  logic [SPILL_W-1:0] spillno,
    input  logic [SLOT_W-1:0]  slotno,
    input  logic [CRATE_W-1:0] crateno,
    input  logic [EVT_W-1:0]   evtno,
    input  logic [2:0]         idx,
    output logic [15:0]        word
);

    // Select the header word layout for the requested index; out-of-range gives idle
    always_comb begin
        word = IDLE_WORD;
        case (idx)
            3'd0:    word = {HDR_MARK, spillno[3:0], slotno, crateno};
            3'd1:    word = {HDR_MARK, evtno[7:0], spillno[9:4]};
            3'd2:    word = {HDR_MARK, timestamp[5:0], evtno[15:8]};
            3'd3:    word = {HDR_MARK, timestamp[19:6]};
            3'd4:    word = {HDR_MARK, 5'b00000, timestamp[28:20]};
            3'd5:    word = {HDR_MARK, 14'h0000};
            default: word = IDLE_WORD;
        endcase
    end

endmodule

// File: rtl/header_encoder.sv
// rtl/header_encoder.sv - ADC event packet framer (optional trailer: HEADER_ENCODER_TRAILER_EN)
module header_encoder
    import header_enc_pkg::*;
#(
    parameter int NSAMPLES = 64,
    parameter int MIN_GAP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_start,
    input  logic [TS_W-1:0]    timestamp,
    input  logic [SPILL_W-1:0] spillno,
    input  logic [SLOT_W-1:0]  slotno,
    input  logic [CRATE_W-1:0] crateno,
    input  logic [EVT_W-1:0]   evtno,
    input  logic [SMP_W-1:0]   pl_data,
    input  logic               pl_valid,
    output logic               pl_ready,
    output logic [15:0]        tx_data,
    output logic               tx_valid,
    output logic               busy,
    output logic               pkt_done,
    output logic               underrun,
    output logic               start_drop
);

    enc_state_t state, state_nxt;

    logic [2:0]         hdr_idx, hdr_idx_nxt;
    logic [31:0]        cnt, cnt_nxt;
    logic [15:0]        tx_data_nxt;
    logic               tx_valid_nxt;
    logic               pkt_done_nxt;
    logic               accept;

    logic [TS_W-1:0]    ts_q,    pack_ts;
    logic [SPILL_W-1:0] spill_q, pack_spill;
    logic [SLOT_W-1:0]  slot_q,  pack_slot;
    logic [CRATE_W-1:0] crate_q, pack_crate;
    logic [EVT_W-1:0]   evt_q,   pack_evt;
    logic [2:0]         pack_idx;
    logic [15:0]        hdr_word;

`ifdef HEADER_ENCODER_TRAILER_EN
    logic [SMP_W-1:0]   acc;
`endif

    // In IDLE the first header word is built from the live inputs so it can be registered on the accepting edge
    always_comb begin
        pack_ts    = ts_q;
        pack_spill = spill_q;
        pack_slot  = slot_q;
        pack_crate = crate_q;
        pack_evt   = evt_q;
        pack_idx   = hdr_idx + 3'd1;
        if (state == ST_IDLE) begin
            pack_ts    = timestamp;
            pack_spill = spillno;
            pack_slot  = slotno;
            pack_crate = crateno;
            pack_evt   = evtno;
            pack_idx   = 3'd0;
        end
    end

    header_word_pack u_pack (
        .timestamp (pack_ts),
        .spillno   (pack_spill),
        .slotno    (pack_slot),
        .crateno   (pack_crate),
        .evtno     (pack_evt),
        .idx       (pack_idx),
        .word      (hdr_word)
    );

    assign busy = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the word to be registered onto tx_data at the coming edge
    always_comb begin
        state_nxt    = state;
        hdr_idx_nxt  = hdr_idx;
        cnt_nxt      = cnt;
        tx_data_nxt  = IDLE_WORD;
        tx_valid_nxt = 1'b0;
        pkt_done_nxt = 1'b0;
        accept       = 1'b0;
        pl_ready     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pkt_start) begin
                    accept       = 1'b1;
                    state_nxt    = ST_HDR;
                    hdr_idx_nxt  = 3'd0;
                    tx_data_nxt  = hdr_word;
                    tx_valid_nxt = 1'b1;
                end
            end
            ST_HDR: begin
                if (hdr_idx == 3'(HDR_WORDS - 1)) begin
                    state_nxt = ST_PAYLOAD;
                    cnt_nxt   = 32'd0;
                end else begin
                    hdr_idx_nxt  = hdr_idx + 3'd1;
                    tx_data_nxt  = hdr_word;
                    tx_valid_nxt = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    tx_data_nxt  = {PL_MARK, pl_data};
                    tx_valid_nxt = 1'b1;
                    if (cnt == 32'(NSAMPLES - 1)) begin
                        cnt_nxt = 32'd0;
`ifdef HEADER_ENCODER_TRAILER_EN
                        state_nxt = ST_TRAIL;
`else
                        state_nxt    = ST_GAP;
                        pkt_done_nxt = 1'b1;
`endif
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            end
            ST_TRAIL: begin
`ifdef HEADER_ENCODER_TRAILER_EN
                tx_data_nxt  = {TRL_MARK, acc};
                tx_valid_nxt = 1'b1;
                pkt_done_nxt = 1'b1;
`endif
                state_nxt = ST_GAP;
                cnt_nxt   = 32'd0;
            end
            ST_GAP: begin
                if (cnt == 32'(MIN_GAP - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 32'd0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output word, counters, latched event fields and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data    <= IDLE_WORD;
            tx_valid   <= 1'b0;
            pkt_done   <= 1'b0;
            hdr_idx    <= 3'd0;
            cnt        <= 32'd0;
            underrun   <= 1'b0;
            start_drop <= 1'b0;
            ts_q       <= '0;
            spill_q    <= '0;
            slot_q     <= '0;
            crate_q    <= '0;
            evt_q      <= '0;
        end else begin
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            pkt_done <= pkt_done_nxt;
            hdr_idx  <= hdr_idx_nxt;
            cnt      <= cnt_nxt;
            if (accept) begin
                ts_q     <= timestamp;
                spill_q  <= spillno;
                slot_q   <= slotno;
                crate_q  <= crateno;
                evt_q    <= evtno;
                underrun <= 1'b0;
            end else if (state == ST_PAYLOAD && !pl_valid) begin
                underrun <= 1'b1;
            end
            if (pkt_start && state != ST_IDLE) begin
                start_drop <= 1'b1;
            end
        end
    end

`ifdef HEADER_ENCODER_TRAILER_EN
    // Running XOR of the packet's payload samples for the trailer word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (state == ST_PAYLOAD && pl_valid) begin
            acc <= acc ^ pl_data;
        end
    end
`endif

endmodule
